// File: rtl/axi4_arb_pkg.sv
// Shared types and the round-robin pick helper used by the 2x1 AXI4 arbiter.
package axi4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // valid must be non-zero; on a tie the master that did not win last time is picked
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    if (valid == 2'b11) return ~last;
    return valid[1];
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle with master/slave views; ID width is set per instance.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_rr_grant.sv
// Two-requester round-robin grant FSM with a registered grant and last-grant pointer.
//   state | meaning
//   IDLE  | no grant held; picks a requester unless blocked
//   GRANT | gnt owns the channel until the downstream handshake
module axi4_rr_grant
  import axi4_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       hs,
  input  logic       block,
  output logic       gnt,
  output logic       active
);

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (!block && (req != 2'b00)) begin
          state_d = GRANT;
          gnt_d   = rr_pick(req, last_q);
        end
      end
      GRANT: begin
        if (hs) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == GRANT);
    gnt    = gnt_q;
  end

endmodule

// File: rtl/axi4_rr_arbiter_2x1.sv
// Shares one AXI4 slave between two masters: independent AW/AR round-robin,
// W steered in AW-grant order, B/R routed back by the extra slave-side ID bit.
module axi4_rr_arbiter_2x1
  import axi4_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int ID_W     = 4,
  parameter int WR_DEPTH = 4
) (
  input logic   clk,
  input logic   rstn,
  axi4_if.slave  m0,
  axi4_if.slave  m1,
  axi4_if.master s
);

  localparam int PTR_W = $clog2(WR_DEPTH);

  logic              aw_g, aw_active, aw_hs;
  logic              ar_g, ar_active, ar_hs;
  logic [ADDR_W-1:0] aw_addr_sel, ar_addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  logic [WR_DEPTH-1:0] wr_order_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      wr_cnt_q;
  logic                fifo_full, fifo_empty, wr_head, push, pop;
  logic                b_sel, r_sel;

  // ---------------- AW ----------------
  axi4_rr_grant u_aw_grant (
    .clk    (clk),
    .rstn   (rstn),
    .req    ({m1.awvalid, m0.awvalid}),
    .hs     (aw_hs),
    .block  (fifo_full),
    .gnt    (aw_g),
    .active (aw_active)
  );

  assign aw_hs       = s.awvalid & s.awready;
  assign aw_addr_sel = aw_g ? m1.awaddr : m0.awaddr;
  assign s.awvalid   = aw_active & (aw_g ? m1.awvalid : m0.awvalid);
  assign s.awid      = {aw_g, (aw_g ? m1.awid : m0.awid)};
  assign s.awaddr    = aw_addr_sel;
  assign s.awlen     = aw_g ? m1.awlen   : m0.awlen;
  assign s.awsize    = aw_g ? m1.awsize  : m0.awsize;
  assign s.awburst   = aw_g ? m1.awburst : m0.awburst;
  assign m0.awready  = aw_active & ~aw_g & s.awready;
  assign m1.awready  = aw_active &  aw_g & s.awready;

  // ---------------- write-order FIFO ----------------
  assign push       = aw_hs;
  assign pop        = s.wvalid & s.wready & s.wlast;
  assign fifo_full  = (wr_cnt_q == (PTR_W+1)'(WR_DEPTH));
  assign fifo_empty = (wr_cnt_q == '0);
  assign wr_head    = wr_order_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_order_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (push) begin
        wr_order_q[wr_ptr_q] <= aw_g;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   wr_cnt_q <= wr_cnt_q + 1'b1;
        2'b01:   wr_cnt_q <= wr_cnt_q - 1'b1;
        default: wr_cnt_q <= wr_cnt_q;
      endcase
    end
  end

  // ---------------- W ----------------
  assign wdata_sel  = wr_head ? m1.wdata : m0.wdata;
  assign s.wvalid   = ~fifo_empty & (wr_head ? m1.wvalid : m0.wvalid);
  assign s.wdata    = wdata_sel;
  assign s.wstrb    = wr_head ? m1.wstrb : m0.wstrb;
  assign s.wlast    = wr_head ? m1.wlast : m0.wlast;
  assign m0.wready  = ~fifo_empty & ~wr_head & s.wready;
  assign m1.wready  = ~fifo_empty &  wr_head & s.wready;

  // B/R are pure pass-through, so they are gated by rstn to stay quiet in reset
  assign b_sel      = s.bid[ID_W];
  assign m0.bvalid  = rstn & s.bvalid & ~b_sel;
  assign m1.bvalid  = rstn & s.bvalid &  b_sel;
  assign m0.bid     = s.bid[ID_W-1:0];
  assign m1.bid     = s.bid[ID_W-1:0];
  assign m0.bresp   = s.bresp;
  assign m1.bresp   = s.bresp;
  assign s.bready   = rstn & (b_sel ? m1.bready : m0.bready);

  // ---------------- AR ----------------
  axi4_rr_grant u_ar_grant (
    .clk    (clk),
    .rstn   (rstn),
    .req    ({m1.arvalid, m0.arvalid}),
    .hs     (ar_hs),
    .block  (1'b0),
    .gnt    (ar_g),
    .active (ar_active)
  );

  assign ar_hs       = s.arvalid & s.arready;
  assign ar_addr_sel = ar_g ? m1.araddr : m0.araddr;
  assign s.arvalid   = ar_active & (ar_g ? m1.arvalid : m0.arvalid);
  assign s.arid      = {ar_g, (ar_g ? m1.arid : m0.arid)};
  assign s.araddr    = ar_addr_sel;
  assign s.arlen     = ar_g ? m1.arlen   : m0.arlen;
  assign s.arsize    = ar_g ? m1.arsize  : m0.arsize;
  assign s.arburst   = ar_g ? m1.arburst : m0.arburst;
  assign m0.arready  = ar_active & ~ar_g & s.arready;
  assign m1.arready  = ar_active &  ar_g & s.arready;

  // ---------------- R ----------------
  assign r_sel      = s.rid[ID_W];
  assign m0.rvalid  = rstn & s.rvalid & ~r_sel;
  assign m1.rvalid  = rstn & s.rvalid &  r_sel;
  assign m0.rid     = s.rid[ID_W-1:0];
  assign m1.rid     = s.rid[ID_W-1:0];
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;
  assign m0.rlast   = s.rlast;
  assign m1.rlast   = s.rlast;
  assign s.rready   = rstn & (r_sel ? m1.rready : m0.rready);

endmodule

// File: tb/tb_axi4_rr_arbiter_2x1.sv
// Directed bench for the 2x1 AXI4 round-robin arbiter.
module tb_axi4_rr_arbiter_2x1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  axi4_if #(.ADDR_W(32), .DATA_W(128), .ID_W(4)) m0_if ();
  axi4_if #(.ADDR_W(32), .DATA_W(128), .ID_W(4)) m1_if ();
  axi4_if #(.ADDR_W(32), .DATA_W(128), .ID_W(5)) s_if ();

  axi4_rr_arbiter_2x1 #(
    .ADDR_W(32), .DATA_W(128), .ID_W(4), .WR_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_if.awid = '0; m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = 3'd4; m0_if.awburst = 2'd1;
    m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '1; m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
    m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = 3'd4; m0_if.arburst = 2'd1;
    m0_if.arvalid = 0; m0_if.rready = 0;
    m1_if.awid = '0; m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = 3'd4; m1_if.awburst = 2'd1;
    m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '1; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 0;
    m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = 3'd4; m1_if.arburst = 2'd1;
    m1_if.arvalid = 0; m1_if.rready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bid = '0; s_if.bresp = '0; s_if.bvalid = 0;
    s_if.arready = 0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 0; s_if.rvalid = 0;

    // reset state, with upstream/downstream valids pushed high to expose ungated paths
    s_if.bvalid = 1; m0_if.bready = 1; s_if.rvalid = 1; m0_if.rready = 1;
    m0_if.awvalid = 1; m0_if.wvalid = 1; m0_if.arvalid = 1; s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
    #12;
    chk("rst_s_awvalid", 128'(s_if.awvalid), 128'(0));
    chk("rst_s_wvalid", 128'(s_if.wvalid), 128'(0));
    chk("rst_s_arvalid", 128'(s_if.arvalid), 128'(0));
    chk("rst_s_bready", 128'(s_if.bready), 128'(0));
    chk("rst_s_rready", 128'(s_if.rready), 128'(0));
    chk("rst_m0_awready", 128'(m0_if.awready), 128'(0));
    chk("rst_m0_wready", 128'(m0_if.wready), 128'(0));
    chk("rst_m0_arready", 128'(m0_if.arready), 128'(0));
    chk("rst_m0_bvalid", 128'(m0_if.bvalid), 128'(0));
    chk("rst_m0_rvalid", 128'(m0_if.rvalid), 128'(0));
    s_if.bvalid = 0; m0_if.bready = 0; s_if.rvalid = 0; m0_if.rready = 0;
    m0_if.awvalid = 0; m0_if.wvalid = 0; m0_if.arvalid = 0;
    @(negedge clk);
    rstn = 1;

    // single master write
    cyc();
    m0_if.awvalid = 1; m0_if.awaddr = 32'h1000; m0_if.awid = 4'h3; m0_if.awlen = 8'd3;
    #1 chk("t1_aw_latency", 128'(s_if.awvalid), 128'(0));
    cyc();
    chk("t1_s_awvalid", 128'(s_if.awvalid), 128'(1));
    chk("t1_s_awid", 128'(s_if.awid), 128'('h03));
    chk("t1_s_awaddr", 128'(s_if.awaddr), 128'('h1000));
    chk("t1_s_awlen", 128'(s_if.awlen), 128'(3));
    chk("t1_m0_awready", 128'(m0_if.awready), 128'(1));
    chk("t1_m1_awready", 128'(m1_if.awready), 128'(0));
    cyc();
    m0_if.awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      m0_if.wvalid = 1; m0_if.wdata = 128'('hC0 + i); m0_if.wlast = (i == 3);
      #1;
      chk("t1_s_wvalid", 128'(s_if.wvalid), 128'(1));
      chk("t1_s_wdata", s_if.wdata, 128'('hC0 + i));
      chk("t1_s_wlast", 128'(s_if.wlast), 128'(i == 3));
      chk("t1_m0_wready", 128'(m0_if.wready), 128'(1));
      cyc();
    end
    #1;
    chk("t1_w_after_pop", 128'(s_if.wvalid), 128'(0));
    chk("t1_m0_wready_off", 128'(m0_if.wready), 128'(0));
    m0_if.wvalid = 0; m0_if.wlast = 0;
    s_if.bvalid = 1; s_if.bid = 5'h03; s_if.bresp = 2'b00; m0_if.bready = 1; m1_if.bready = 0;
    #1;
    chk("t1_m0_bvalid", 128'(m0_if.bvalid), 128'(1));
    chk("t1_m0_bid", 128'(m0_if.bid), 128'(3));
    chk("t1_m1_bvalid", 128'(m1_if.bvalid), 128'(0));
    chk("t1_s_bready", 128'(s_if.bready), 128'(1));
    cyc();
    s_if.bvalid = 0; m0_if.bready = 0;

    // simultaneous AR, three rounds: m0, m1, m0
    m0_if.arvalid = 1; m0_if.arid = 4'hA; m0_if.araddr = 32'h2000;
    m1_if.arvalid = 1; m1_if.arid = 4'hB; m1_if.araddr = 32'h3000;
    #1 chk("t2_ar_latency", 128'(s_if.arvalid), 128'(0));
    for (int r = 0; r < 3; r++) begin
      cyc();
      chk("t2_s_arvalid", 128'(s_if.arvalid), 128'(1));
      chk("t2_s_arid", 128'(s_if.arid), (r == 1) ? 128'('h1B) : 128'('h0A));
      chk("t2_s_araddr", 128'(s_if.araddr), (r == 1) ? 128'('h3000) : 128'('h2000));
      chk("t2_m0_arready", 128'(m0_if.arready), 128'(r != 1));
      chk("t2_m1_arready", 128'(m1_if.arready), 128'(r == 1));
      cyc();
      chk("t2_ar_gap", 128'(s_if.arvalid), 128'(0));
    end
    m0_if.arvalid = 0; m1_if.arvalid = 0;

    // W ordering: m1 AW first, m0 presents W early
    cyc();
    m1_if.awvalid = 1; m1_if.awid = 4'h1; m1_if.awlen = 8'd1; m1_if.awaddr = 32'h4000;
    m0_if.wvalid = 1; m0_if.wdata = 128'hD0; m0_if.wlast = 1;
    #1;
    chk("t3_w_before_aw", 128'(s_if.wvalid), 128'(0));
    chk("t3_m0_wready_early", 128'(m0_if.wready), 128'(0));
    cyc();
    chk("t3_s_awid_m1", 128'(s_if.awid), 128'('h11));
    chk("t3_m1_awready", 128'(m1_if.awready), 128'(1));
    chk("t3_w_still_held", 128'(s_if.wvalid), 128'(0));
    cyc();
    m1_if.awvalid = 0;
    m0_if.awvalid = 1; m0_if.awid = 4'h2; m0_if.awlen = 8'd0; m0_if.awaddr = 32'h5000;
    #1;
    chk("t3_head_m1_blocks_m0", 128'(s_if.wvalid), 128'(0));
    chk("t3_m0_wready_blocked", 128'(m0_if.wready), 128'(0));
    cyc();
    m1_if.wvalid = 1; m1_if.wdata = 128'hB0; m1_if.wlast = 0;
    #1;
    chk("t3_s_awid_m0", 128'(s_if.awid), 128'('h02));
    chk("t3_s_wvalid_m1b0", 128'(s_if.wvalid), 128'(1));
    chk("t3_s_wdata_m1b0", s_if.wdata, 128'hB0);
    chk("t3_m1_wready", 128'(m1_if.wready), 128'(1));
    chk("t3_m0_wready_b0", 128'(m0_if.wready), 128'(0));
    cyc();
    m0_if.awvalid = 0;
    m1_if.wdata = 128'hB1; m1_if.wlast = 1;
    #1;
    chk("t3_s_wdata_m1b1", s_if.wdata, 128'hB1);
    chk("t3_s_wlast_m1b1", 128'(s_if.wlast), 128'(1));
    cyc();
    m1_if.wvalid = 0; m1_if.wlast = 0;
    #1;
    chk("t3_s_wvalid_m0", 128'(s_if.wvalid), 128'(1));
    chk("t3_s_wdata_m0", s_if.wdata, 128'hD0);
    chk("t3_m0_wready", 128'(m0_if.wready), 128'(1));
    chk("t3_m1_wready_off", 128'(m1_if.wready), 128'(0));
    cyc();
    chk("t3_fifo_drained", 128'(s_if.wvalid), 128'(0));
    m0_if.wvalid = 0; m0_if.wlast = 0;

    // FIFO full: four m1 AWs, then m0 is held off until a WLAST drains one slot
    cyc();
    m1_if.awvalid = 1; m1_if.awid = 4'h4; m1_if.awlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_fill_awvalid", 128'(s_if.awvalid), 128'(1));
      chk("t4_fill_m1_awready", 128'(m1_if.awready), 128'(1));
      cyc();
    end
    m1_if.awvalid = 0;
    m0_if.awvalid = 1; m0_if.awid = 4'h5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_full_m0_awready", 128'(m0_if.awready), 128'(0));
      chk("t4_full_s_awvalid", 128'(s_if.awvalid), 128'(0));
      cyc();
    end
    m1_if.wvalid = 1; m1_if.wlast = 1; m1_if.wdata = 128'hB0;
    #1;
    chk("t4_first_wlast_valid", 128'(s_if.wvalid), 128'(1));
    chk("t4_first_wlast_m1", 128'(m1_if.wready), 128'(1));
    chk("t4_still_blocked", 128'(m0_if.awready), 128'(0));
    cyc();
    m1_if.wvalid = 0;
    #1 chk("t4_idle_after_pop", 128'(s_if.awvalid), 128'(0));
    cyc();
    chk("t4_grant_resumes", 128'(s_if.awvalid), 128'(1));
    chk("t4_resume_awid", 128'(s_if.awid), 128'('h05));
    chk("t4_resume_m0_awready", 128'(m0_if.awready), 128'(1));
    cyc();
    m0_if.awvalid = 0;
    m0_if.wvalid = 1; m0_if.wdata = 128'hA0; m0_if.wlast = 1;
    m1_if.wvalid = 1; m1_if.wdata = 128'hB0; m1_if.wlast = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_drain_wvalid", 128'(s_if.wvalid), 128'(1));
      chk("t4_drain_wdata", s_if.wdata, (i < 3) ? 128'hB0 : 128'hA0);
      cyc();
    end
    #1 chk("t4_drain_empty", 128'(s_if.wvalid), 128'(0));
    m0_if.wvalid = 0; m1_if.wvalid = 0; m0_if.wlast = 0; m1_if.wlast = 0;

    // read response to m1 while both masters contend for AW
    cyc();
    m0_if.awvalid = 1; m0_if.awid = 4'h6;
    m1_if.awvalid = 1; m1_if.awid = 4'h7;
    s_if.rvalid = 1; s_if.rid = 5'h12; s_if.rdata = 128'hCAFE; s_if.rlast = 1;
    m1_if.rready = 1; m0_if.rready = 0;
    #1;
    chk("t5_m1_rvalid", 128'(m1_if.rvalid), 128'(1));
    chk("t5_m1_rid", 128'(m1_if.rid), 128'(2));
    chk("t5_m0_rvalid", 128'(m0_if.rvalid), 128'(0));
    chk("t5_m1_rdata", m1_if.rdata, 128'hCAFE);
    chk("t5_m1_rlast", 128'(m1_if.rlast), 128'(1));
    chk("t5_s_rready", 128'(s_if.rready), 128'(1));
    cyc();
    chk("t5_s_awid", 128'(s_if.awid), 128'('h17));
    chk("t5_m1_awready", 128'(m1_if.awready), 128'(1));
    chk("t5_m0_awready", 128'(m0_if.awready), 128'(0));
    chk("t5_m1_rvalid_hold", 128'(m1_if.rvalid), 128'(1));
    cyc();
    m0_if.awvalid = 0; m1_if.awvalid = 0;
    s_if.rvalid = 0; m1_if.rready = 0; s_if.rlast = 0;
    #1 chk("t5_m1_rvalid_off", 128'(m1_if.rvalid), 128'(0));

    // reset mid-burst: drain pending m1 entry, start a 4-beat m0 burst, reset on beat 2
    m1_if.wvalid = 1; m1_if.wlast = 1;
    #1 chk("t6_drain_m1", 128'(m1_if.wready), 128'(1));
    cyc();
    m1_if.wvalid = 0; m1_if.wlast = 0;
    m0_if.awvalid = 1; m0_if.awid = 4'h3; m0_if.awlen = 8'd3;
    cyc();
    chk("t6_aw_grant", 128'(s_if.awid), 128'('h03));
    cyc();
    m0_if.awvalid = 0;
    m0_if.wvalid = 1; m0_if.wlast = 0; m0_if.wdata = 128'hC0;
    cyc();
    m0_if.wdata = 128'hC1;
    cyc();
    m0_if.wdata = 128'hC2;
    s_if.bvalid = 1; s_if.bid = 5'h00; m0_if.bready = 1;
    s_if.rvalid = 1; s_if.rid = 5'h00; m0_if.rready = 1;
    m0_if.awvalid = 1; m1_if.awvalid = 1; m1_if.awid = 4'h9;
    m0_if.arvalid = 1; m1_if.arvalid = 1;
    #1;
    chk("t6_pre_wvalid", 128'(s_if.wvalid), 128'(1));
    chk("t6_pre_wdata", s_if.wdata, 128'hC2);
    rstn = 0;
    #1;
    chk("t6_rst_s_wvalid", 128'(s_if.wvalid), 128'(0));
    chk("t6_rst_m0_wready", 128'(m0_if.wready), 128'(0));
    chk("t6_rst_s_awvalid", 128'(s_if.awvalid), 128'(0));
    chk("t6_rst_s_arvalid", 128'(s_if.arvalid), 128'(0));
    chk("t6_rst_s_bready", 128'(s_if.bready), 128'(0));
    chk("t6_rst_s_rready", 128'(s_if.rready), 128'(0));
    chk("t6_rst_m0_bvalid", 128'(m0_if.bvalid), 128'(0));
    chk("t6_rst_m0_rvalid", 128'(m0_if.rvalid), 128'(0));
    chk("t6_rst_m0_awready", 128'(m0_if.awready), 128'(0));
    chk("t6_rst_m0_arready", 128'(m0_if.arready), 128'(0));
    s_if.bvalid = 0; s_if.rvalid = 0; m0_if.bready = 0; m0_if.rready = 0;
    @(negedge clk);
    rstn = 1;
    #1;
    chk("t6_post_fifo_empty", 128'(s_if.wvalid), 128'(0));
    chk("t6_post_awvalid_idle", 128'(s_if.awvalid), 128'(0));
    cyc();
    chk("t6_tie_awid", 128'(s_if.awid), 128'('h03));
    chk("t6_tie_m0_awready", 128'(m0_if.awready), 128'(1));
    chk("t6_tie_m1_awready", 128'(m1_if.awready), 128'(0));
    chk("t6_tie_arid", 128'(s_if.arid), 128'('h0A));
    chk("t6_post_wvalid", 128'(s_if.wvalid), 128'(0));
    m0_if.awvalid = 0; m1_if.awvalid = 0; m0_if.arvalid = 0; m1_if.arvalid = 0; m0_if.wvalid = 0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
